hex_keypad_emulator: RTL

Behavioural-synthesizable model of the Grayhill 072 4x4 hex keypad, the passive end of the row/column scan interface. A test controller requests a key press by code. The block drives the keypad's Row lines in response to the scanner's Col outputs, with programmable contact bounce, hold time and release gap. It sits opposite the keypad scanner in loopback benches and FPGA self-test builds, and also produces the scanner's S_Row input.

---
 rtl/hex_keypad_pkg.sv | 32 +++
 rtl/hex_keypad_sync2.sv | 22 ++
 rtl/hex_keypad_emulator.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/hex_keypad_pkg.sv
// rtl/hex_keypad_pkg.sv - shared types, widths and key decode helpers for the hex keypad emulator
package hex_keypad_pkg;

    localparam int KEY_W = 4;
    localparam int ROW_W = 4;
    localparam int COL_W = 4;

    localparam logic [4:0] ST_IDLE       = 5'b00001;
    localparam logic [4:0] ST_BOUNCE_IN  = 5'b00010;
    localparam logic [4:0] ST_HOLD       = 5'b00100;
    localparam logic [4:0] ST_BOUNCE_OUT = 5'b01000;
    localparam logic [4:0] ST_GAP        = 5'b10000;

    typedef enum logic [4:0] {
        S_IDLE       = ST_IDLE,
        S_BOUNCE_IN  = ST_BOUNCE_IN,
        S_HOLD       = ST_HOLD,
        S_BOUNCE_OUT = ST_BOUNCE_OUT,
        S_GAP        = ST_GAP
    } state_t;

    // Row line index a key lives on
    function automatic logic [1:0] key_row(input logic [KEY_W-1:0] code);
        return code[3:2];
    endfunction

    // Column line index a key lives on
    function automatic logic [1:0] key_col(input logic [KEY_W-1:0] code);
        return code[1:0];
    endfunction

endpackage

// File: rtl/hex_keypad_sync2.sv
// rtl/hex_keypad_sync2.sv - generic 1-bit two-flop synchronizer with synchronous reset
module hex_keypad_sync2 (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage shift; both stages clear on reset
    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/hex_keypad_emulator.sv
// rtl/hex_keypad_emulator.sv - passive 4x4 keypad model driving Row from Col with bounce, hold and gap
import hex_keypad_pkg::*;

module hex_keypad_emulator #(
    parameter int HOLD_W        = 16,
    parameter int BOUNCE_CYCLES = 4,
    parameter int GAP_CYCLES    = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [COL_W-1:0]  Col,
    input  logic [KEY_W-1:0]  key_code,
    input  logic [HOLD_W-1:0] hold_len,
    input  logic              press_req,
    output logic              press_ack,
    output logic              busy,
    output logic              done,
    output logic              contact,
    output logic [ROW_W-1:0]  Row,
    output logic              S_Row
);

    localparam logic [HOLD_W-1:0] BOUNCE_LOAD = HOLD_W'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
    localparam logic [HOLD_W-1:0] GAP_LOAD    = HOLD_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [HOLD_W-1:0] ONE         = HOLD_W'(1);

    state_t             state, state_next;
    logic [HOLD_W-1:0]  cnt, cnt_next;
    logic [HOLD_W-1:0]  hold_r, hold_in;
    logic [KEY_W-1:0]   key_r;
    logic               contact_next;
    logic               ack_next, done_next, latch;

    assign hold_in = (hold_len == '0) ? ONE : hold_len;
    assign busy    = (state != S_IDLE);

    // Next state, phase counter reload, and the contact waveform for the next cycle
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        contact_next = contact;
        ack_next     = 1'b0;
        done_next    = 1'b0;
        latch        = 1'b0;
        case (state)
            S_IDLE: begin
                contact_next = 1'b0;
                if (press_req) begin
                    latch        = 1'b1;
                    ack_next     = 1'b1;
                    contact_next = 1'b1;
                    if (BOUNCE_CYCLES == 0) begin
                        state_next = S_HOLD;
                        cnt_next   = hold_in - ONE;
                    end else begin
                        state_next = S_BOUNCE_IN;
                        cnt_next   = BOUNCE_LOAD;
                    end
                end
            end
            S_BOUNCE_IN: begin
                if (cnt == '0) begin
                    state_next   = S_HOLD;
                    cnt_next     = hold_r - ONE;
                    contact_next = 1'b1;
                end else begin
                    cnt_next     = cnt - ONE;
                    contact_next = ~contact;
                end
            end
            S_HOLD: begin
                if (cnt == '0) begin
                    contact_next = 1'b0;
                    if (BOUNCE_CYCLES == 0) begin
                        state_next = S_GAP;
                        cnt_next   = GAP_LOAD;
                    end else begin
                        state_next = S_BOUNCE_OUT;
                        cnt_next   = BOUNCE_LOAD;
                    end
                end else begin
                    cnt_next     = cnt - ONE;
                    contact_next = 1'b1;
                end
            end
            S_BOUNCE_OUT: begin
                if (cnt == '0) begin
                    state_next   = S_GAP;
                    cnt_next     = GAP_LOAD;
                    contact_next = 1'b0;
                end else begin
                    cnt_next     = cnt - ONE;
                    contact_next = ~contact;
                end
            end
            S_GAP: begin
                contact_next = 1'b0;
                if (cnt == '0) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt - ONE;
                end
            end
            default: begin
                state_next   = S_IDLE;
                contact_next = 1'b0;
            end
        endcase
    end

    // State register, latched request and registered pulses
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            contact   <= 1'b0;
            key_r     <= '0;
            hold_r    <= '0;
            press_ack <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            contact   <= contact_next;
            press_ack <= ack_next;
            done      <= done_next;
            if (latch) begin
                key_r  <= key_code;
                hold_r <= hold_in;
            end
        end
    end

    // Only the latched key's row follows its column, gated by the switch contact
    always_comb begin
        Row = '0;
        Row[key_row(key_r)] = contact & Col[key_col(key_r)];
    end

    hex_keypad_sync2 u_sync (
        .clock (clock),
        .reset (reset),
        .d     (|Row),
        .q     (S_Row)
    );

endmodule
